prefetch_buffer: RTL and testbench

Instruction prefetch buffer between instruction memory and the fetch stage. It generates sequential word addresses and issues them to instruction memory under a request/grant handshake. Returned words are queued with their PCs in a DEPTH-entry FIFO and presented to fetch under a valid/ready handshake. Redirects from branches, jumps and flushes discard all queued and in-flight words and restart fetching at the new PC.

---
 rtl/prefetch_buffer.sv | 146 ++++++++++++++
 tb/tb_prefetch_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_buffer
// Summary  : Sequential instruction prefetcher with a DEPTH-entry {pc, instr}
//            FIFO, credit-limited memory requests and redirect discard.
// Options  : PREFETCH_BYPASS_EN - present a response on the output in the
//            same cycle when the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] count;
  logic [CW:0]   in_use;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] pq_wr, pq_rd;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   pq_mem     [DEPTH];

  logic          grant;
  logic          live_rsp;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [31:0]   rsp_pc;

  // Words still in flight toward a cleared FIFO keep their credit until they return.
  assign in_use      = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_o  = !rst_i && (in_use < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o && imem_gnt_i;

  assign live_rsp = imem_rvalid_i && (discard_cnt == '0) && !redirect_i;
  assign rsp_pc   = pq_mem[pq_rd];

`ifdef PREFETCH_BYPASS_EN
  assign bypass        = live_rsp && (count == '0);
  assign instr_valid_o = (count != '0) || bypass;
  assign instr_o       = bypass ? imem_rdata_i : fifo_instr[rd_ptr];
  assign instr_pc_o    = bypass ? rsp_pc       : fifo_pc[rd_ptr];
`else
  assign bypass        = 1'b0;
  assign instr_valid_o = (count != '0);
  assign instr_o       = fifo_instr[rd_ptr];
  assign instr_pc_o    = fifo_pc[rd_ptr];
`endif

  assign pop  = (count != '0) && instr_ready_i && !redirect_i;
  assign push = live_rsp && !(bypass && instr_ready_i);

  always_comb begin
    outstanding_nxt = outstanding;
    case ({grant, imem_rvalid_i})
      2'b10:   outstanding_nxt = outstanding + 1'b1;
      2'b01:   outstanding_nxt = outstanding - 1'b1;
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
        pq_mem[i]     <= '0;
      end
    end else begin
      outstanding <= outstanding_nxt;

      if (redirect_i)
        fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
      else if (grant)
        fetch_pc <= fetch_pc + 32'd4;

      // The PC queue is never flushed: discarded responses still retire their slot.
      if (grant) begin
        pq_mem[pq_wr] <= fetch_pc;
        pq_wr         <= pq_wr + 1'b1;
      end
      if (imem_rvalid_i)
        pq_rd <= pq_rd + 1'b1;

      // Everything in flight after this cycle, including a same-cycle grant, is stale.
      if (redirect_i)
        discard_cnt <= outstanding_nxt;
      else if (imem_rvalid_i && (discard_cnt != '0))
        discard_cnt <= discard_cnt - 1'b1;

      if (redirect_i) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          fifo_pc[wr_ptr]    <= rsp_pc;
          fifo_instr[wr_ptr] <= imem_rdata_i;
          wr_ptr             <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (count == CW'(DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_prefetch_buffer.sv
`default_nettype none
// Scoreboard bench for prefetch_buffer: a memory model tags each grant with a
// redirect epoch, and only current-epoch words are expected at the output.
module tb_prefetch_buffer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_BYPASS_EN
  localparam int LAT_ADD = 0;
`else
  localparam int LAT_ADD = 1;
`endif

  typedef struct { logic [31:0] addr; int epoch; int rdy; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] d; } ent_t;

  logic        clk = 1'b0;
  logic        rst, redirect, gnt, rvalid, ready;
  logic [31:0] redirect_pc, rdata;
  logic        imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, instr_o, instr_pc_o;

  logic        wrap_req, wrap_valid;
  logic [31:0] wrap_addr, wrap_instr, wrap_pc;
  logic        wrap_gnt = 1'b1, wrap_rvalid = 1'b0, wrap_ready = 1'b1, wrap_redirect = 1'b0;
  logic [31:0] wrap_rdata = 32'h0, wrap_redirect_pc = 32'h0;

  int checks = 0, errors = 0;
  int cyc = 0, epoch = 0, grants = 0, pops = 0, stall = 0;
  int gnt_mode, ready_mode, lat_min, lat_max;
  int first_rsp_cyc, first_pop_cyc;
  logic [31:0] exp_addr;
  logic last_req, last_valid, prev_redirect;
  logic [31:0] last_addr;
  mreq_t mq[$];
  ent_t  sb[$];
  logic [31:0] pc_log[$];

  always #5 clk = ~clk;

  prefetch_buffer #(.DEPTH(4), .RESET_PC(RESET_PC)) u_dut (
    .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_ready_i(ready));

  prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk_i(clk), .rst_i(rst), .redirect_i(wrap_redirect), .redirect_pc_i(wrap_redirect_pc),
    .imem_req_o(wrap_req), .imem_addr_o(wrap_addr), .imem_gnt_i(wrap_gnt),
    .imem_rvalid_i(wrap_rvalid), .imem_rdata_i(wrap_rdata), .instr_valid_o(wrap_valid),
    .instr_o(wrap_instr), .instr_pc_o(wrap_pc), .instr_ready_i(wrap_ready));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic clear_model();
    mq.delete(); sb.delete(); pc_log.delete();
    epoch++;
    exp_addr = RESET_PC;
    first_rsp_cyc = -1; first_pop_cyc = -1;
    stall = 0; prev_redirect = 1'b0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle();
    mreq_t m;
    bit    cur, popped;
    cur = 0; popped = 0;
    m = '{addr: 32'h0, epoch: -1, rdy: 0};
    rvalid = 1'b0; rdata = 32'h0;
    if (mq.size() > 0 && mq[0].rdy <= cyc) begin
      m = mq.pop_front();
      rvalid = 1'b1; rdata = mem_word(m.addr); cur = 1;
    end
    gnt   = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : (gnt_mode == 1);
    ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    #1;
    last_req = imem_req_o; last_addr = imem_addr_o; last_valid = instr_valid_o;
    if (imem_req_o) begin
      checks++;
      if (imem_addr_o !== exp_addr) begin
        errors++; $display("FAIL imem_addr: got %h expected %h", imem_addr_o, exp_addr);
      end
    end
    if (prev_redirect) begin
      checks++;
      if (instr_valid_o !== 1'b0) begin
        errors++; $display("FAIL valid_after_redirect: got %b expected 0", instr_valid_o);
      end
    end
    if (cur && m.epoch == epoch && !redirect) begin
      sb.push_back('{pc: m.addr, d: mem_word(m.addr)});
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
    end
    if (instr_valid_o && ready && !redirect) begin
      checks++; popped = 1; pops++;
      pc_log.push_back(instr_pc_o);
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      if (sb.size() == 0) begin
        errors++; $display("FAIL spurious_pop: got pc %h expected no valid entry", instr_pc_o);
      end else begin
        ent_t e;
        e = sb.pop_front();
        if (instr_pc_o !== e.pc || instr_o !== e.d) begin
          errors++;
          $display("FAIL pop: got pc %h instr %h expected pc %h instr %h", instr_pc_o, instr_o, e.pc, e.d);
        end
      end
    end
    if (imem_req_o && gnt) begin
      mq.push_back('{addr: exp_addr, epoch: epoch, rdy: cyc + int'($urandom_range(lat_max, lat_min))});
      exp_addr = exp_addr + 32'd4;
      grants++;
    end
    prev_redirect = redirect;
    if (redirect) begin
      sb.delete(); epoch++; stall = 0;
      exp_addr = redirect_pc & 32'hFFFF_FFFC;
    end
    if (sb.size() > 0 && ready && !popped) stall++; else stall = 0;
    if (stall > 40) begin
      checks++; errors++; stall = 0;
      $display("FAIL watchdog: got no output for 40 ready cycles expected %0d queued entries", sb.size());
    end
    @(posedge clk); @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; gnt = 1'b0; rvalid = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    clear_model();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; gnt = 1'b0; rvalid = 1'b0;
    rdata = 32'h0; ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== RESET_PC || instr_valid_o !== 1'b0 ||
        instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: got req %b addr %h valid %b instr %h pc %h expected 0 %h 0 0 0",
               imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, RESET_PC);
    end
    @(negedge clk);
    clear_model();
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b1) begin
      errors++; $display("FAIL req_after_reset: got %b expected 1", imem_req_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_fetch();
    int p0;
    do_reset();
    gnt_mode = 1; ready_mode = 1; lat_min = 1; lat_max = 1;
    p0 = pops;
    run(16);
    checks++;
    if (first_pop_cyc - first_rsp_cyc != LAT_ADD) begin
      errors++; $display("FAIL latency: got %0d expected %0d", first_pop_cyc - first_rsp_cyc, LAT_ADD);
    end
    checks++;
    if (pc_log.size() == 0 || pc_log[0] !== RESET_PC) begin
      errors++; $display("FAIL first_pc: got %0d entries expected first pc %h", pc_log.size(), RESET_PC);
    end
    checks++;
    if (pops - p0 < 15 - LAT_ADD) begin
      errors++; $display("FAIL throughput: got %0d pops expected %0d", pops - p0, 15 - LAT_ADD);
    end
  endtask

  task automatic test_backpressure();
    int g0;
    do_reset();
    gnt_mode = 1; ready_mode = 0; lat_min = 1; lat_max = 1;
    g0 = grants;
    run(8);
    checks++;
    if (grants - g0 != 4 || last_req !== 1'b0) begin
      errors++; $display("FAIL credit_limit: got %0d grants req %b expected 4 grants req 0", grants - g0, last_req);
    end
    ready_mode = 1; g0 = grants;
    run(10);
    checks++;
    if (pc_log.size() < 4) begin
      errors++; $display("FAIL drain_count: got %0d pops expected at least 4", pc_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pc_log[i] !== 32'(4 * i)) begin
          errors++; $display("FAIL drain_order: got pc %h expected %h", pc_log[i], 32'(4 * i));
        end
      end
    end
    checks++;
    if (grants == g0) begin
      errors++; $display("FAIL resume: got 0 new grants expected more than 0");
    end
  endtask

  // Redirect, then require the first post-redirect output to carry target_pc.
  task automatic redirect_and_check(input logic [31:0] pc, input logic [31:0] target_pc, input int settle);
    int n0;
    redirect = 1'b1; redirect_pc = pc;
    cycle();
    redirect = 1'b0;
    n0 = pc_log.size();
    cycle();
    checks++;
    if (last_addr !== target_pc) begin
      errors++; $display("FAIL redirect_addr: got %h expected %h", last_addr, target_pc);
    end
    run(settle);
    checks++;
    if (pc_log.size() <= n0 || pc_log[n0] !== target_pc) begin
      errors++; $display("FAIL redirect_first_pc: got %0d entries expected first pc %h", pc_log.size() - n0, target_pc);
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    gnt_mode = 1; ready_mode = 1; lat_min = 2; lat_max = 2;
    run(6);
    redirect_and_check(32'h0000_0100, 32'h0000_0100, 10);
  endtask

  task automatic test_redirect_ungranted();
    do_reset();
    gnt_mode = 1; ready_mode = 1; lat_min = 3; lat_max = 3;
    run(3);
    gnt_mode = 0;
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    cycle();
    redirect = 1'b0;
    cycle();
    checks++;
    if (last_addr !== 32'h0000_0200 || last_req !== 1'b1) begin
      errors++; $display("FAIL ungranted_redirect: got addr %h req %b expected 00000200 1", last_addr, last_req);
    end
    run(3);
    gnt_mode = 1;
    run(12);
    checks++;
    if (pc_log.size() == 0 || pc_log[pc_log.size() - 12 + 2 - 2] === 32'hx) begin
      errors++; $display("FAIL ungranted_output: got %0d entries expected some", pc_log.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    gnt_mode = 1; ready_mode = 1; lat_min = 1; lat_max = 3;
    run(5);
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    cycle();
    redirect_pc = 32'h0000_0400;
    cycle();
    redirect = 1'b0;
    cycle();
    redirect_and_check(32'h0000_0502, 32'h0000_0500, 15);
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_mode = 0; ready_mode = 1; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (wrap_req !== 1'b1 || wrap_addr !== 32'hFFFF_FFF8 + 32'(4 * i)) begin
        errors++;
        $display("FAIL wrap_addr: got req %b addr %h expected 1 %h", wrap_req, wrap_addr, 32'hFFFF_FFF8 + 32'(4 * i));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    gnt_mode = 1; ready_mode = 0; lat_min = 1; lat_max = 1;
    run(4);
    #1;
    checks++;
    if (instr_valid_o !== 1'b1 || sb.size() != 3) begin
      errors++; $display("FAIL prefill: got valid %b model %0d expected valid 1 with 3", instr_valid_o, sb.size());
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      errors++; $display("FAIL async_reset: got valid %b req %b expected 0 0", instr_valid_o, imem_req_o);
    end
    @(negedge clk);
    @(negedge clk);
    clear_model();
    rst = 1'b0;
    ready_mode = 1;
    run(8);
    checks++;
    if (pc_log.size() == 0 || pc_log[0] !== RESET_PC) begin
      errors++; $display("FAIL restart_pc: got %0d entries expected first pc %h", pc_log.size(), RESET_PC);
    end
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    gnt_mode = 2; ready_mode = 2; lat_min = 1; lat_max = 3;
    p0 = pops;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        redirect = 1'b1; redirect_pc = $urandom;
      end
      cycle();
      redirect = 1'b0;
    end
    checks++;
    if (pops - p0 < 50) begin
      errors++; $display("FAIL random_progress: got %0d pops expected at least 50", pops - p0);
    end
  endtask

  initial begin
    gnt_mode = 0; ready_mode = 0; lat_min = 1; lat_max = 1;
    exp_addr = RESET_PC; last_req = 1'b0; last_valid = 1'b0; last_addr = 32'h0;
    prev_redirect = 1'b0; first_rsp_cyc = -1; first_pop_cyc = -1;
    test_reset();
    test_reset_fetch();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_ungranted();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
